tick_debouncer: RTL and testbench

Debounces one raw mechanical switch input, using the single-cycle `max_tick` strobe of the free-running 16-bit tick counter as its time base. The block sits directly downstream of that counter. It produces a clean level plus one-cycle rise/fall pulses for the control logic. Debounce time is `CONFIRM_TICKS` tick periods, and each tick period is `max_count + 1` clock cycles as set on the counter.

---
 rtl/tick_debouncer.sv | 122 ++++++++++++
 tb/tb_tick_debouncer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/tick_debouncer.sv
// Switch debouncer timed by an external tick strobe: level output plus rise/fall pulses.
// Define TICK_DEBOUNCER_SYNC_EN to put a 2-flop synchronizer in front of the FSM.
//
// state | meaning
// ZERO  | debounced level 0, input stable low
// WAIT1 | level 0, input high, counting ticks to confirm
// ONE   | debounced level 1, input stable high
// WAIT0 | level 1, input low, counting ticks to confirm
module tick_debouncer #(
   parameter int unsigned CONFIRM_TICKS = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic tick,
   input  logic sw,
   output logic db_level,
   output logic db_rise,
   output logic db_fall
);

   typedef enum logic [1:0] {
      ZERO  = 2'd0,
      WAIT1 = 2'd1,
      ONE   = 2'd2,
      WAIT0 = 2'd3
   } state_t;

   localparam logic [7:0] LAST = 8'(CONFIRM_TICKS - 1);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       rise_q, rise_d;
   logic       fall_q, fall_d;
   logic       sw_s;

`ifdef TICK_DEBOUNCER_SYNC_EN
   logic sync1_q, sync2_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= sw;
         sync2_q <= sync1_q;
      end
   end

   assign sw_s = sync2_q;
`else
   assign sw_s = sw;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ZERO;
         cnt_q   <= 8'd0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   // A bounce back to the stable level wins over a coincident tick.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
         ZERO: begin
            if (sw_s) begin
               state_d = WAIT1;
               cnt_d   = 8'd0;
            end
         end
         WAIT1: begin
            if (!sw_s) begin
               state_d = ZERO;
            end else if (tick) begin
               if (cnt_q == LAST) begin
                  state_d = ONE;
                  rise_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         ONE: begin
            if (!sw_s) begin
               state_d = WAIT0;
               cnt_d   = 8'd0;
            end
         end
         WAIT0: begin
            if (sw_s) begin
               state_d = ONE;
            end else if (tick) begin
               if (cnt_q == LAST) begin
                  state_d = ZERO;
                  fall_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         default: begin
            state_d = ZERO;
            cnt_d   = 8'd0;
         end
      endcase
   end

   assign db_level = (state_q == ONE) || (state_q == WAIT0);
   assign db_rise  = rise_q;
   assign db_fall  = fall_q;

endmodule

// File: tb/tb_tick_debouncer.sv
// Scoreboard bench for tick_debouncer: the driver predicts per-cycle outputs from a
// tick-counting model of the debounce rule, and a monitor compares them after each edge.
module tb_tick_debouncer;
   localparam int N = 3;
`ifdef TICK_DEBOUNCER_SYNC_EN
   localparam int SIM_OFS = 27;
`else
   localparam int SIM_OFS = 29;
`endif

   logic clk = 1'b0;
   logic reset, tick, sw;
   logic db_level, db_rise, db_fall;

   always #5 clk = ~clk;

   tick_debouncer #(.CONFIRM_TICKS(N)) dut (
      .clk(clk),
      .reset(reset),
      .tick(tick),
      .sw(sw),
      .db_level(db_level),
      .db_rise(db_rise),
      .db_fall(db_fall)
   );

   typedef struct packed {
      logic lvl;
      logic rise;
      logic fall;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   mon_cyc = 0;
   bit   started = 0;

   // Model: the level flips once N ticks have arrived after the first cycle of an
   // unbroken run of the opposite input value.
   logic m_lvl = 1'b0;
   bit   m_run = 0;
   int   m_ticks = 0;
`ifdef TICK_DEBOUNCER_SYNC_EN
   logic m_s1 = 1'b0, m_s2 = 1'b0;
`endif

   task automatic model_edge(input logic r, input logic s, input logic t);
      exp_t e;
      logic sws;
`ifdef TICK_DEBOUNCER_SYNC_EN
      sws = m_s2;
`else
      sws = s;
`endif
      e.rise = 1'b0;
      e.fall = 1'b0;
      if (!r) begin
         m_lvl = 1'b0;
         m_run = 0;
         m_ticks = 0;
`ifdef TICK_DEBOUNCER_SYNC_EN
         m_s1 = 1'b0;
         m_s2 = 1'b0;
`endif
      end else begin
         if (sws != m_lvl) begin
            if (!m_run) begin
               m_run = 1;
               m_ticks = 0;
            end else if (t) begin
               m_ticks++;
               if (m_ticks == N) begin
                  m_lvl = ~m_lvl;
                  if (m_lvl) e.rise = 1'b1;
                  else e.fall = 1'b1;
                  m_run = 0;
               end
            end
         end else begin
            m_run = 0;
         end
`ifdef TICK_DEBOUNCER_SYNC_EN
         m_s2 = m_s1;
         m_s1 = s;
`endif
      end
      e.lvl = m_lvl;
      exp_q.push_back(e);
   endtask

   task automatic step(input logic r, input logic s, input logic t);
      @(negedge clk);
      reset = r;
      sw    = s;
      tick  = t;
      model_edge(r, s, t);
      started = 1;
      cyc++;
   endtask

   task automatic step_p(input logic r, input logic s);
      step(r, s, (cyc % 10) == 9);
   endtask

   task automatic align();
      while ((cyc % 10) != 0) step_p(1'b1, sw);
   endtask

   task automatic chk(input string name, input logic act, input logic expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %b expected %b", name, mon_cyc, act, expv);
      end
   endtask

   initial begin
      exp_t e;
      wait (started);
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_underflow at cycle %0d: got empty queue expected entry", mon_cyc);
         end else begin
            e = exp_q.pop_front();
            chk("db_level", db_level, e.lvl);
            chk("db_rise", db_rise, e.rise);
            chk("db_fall", db_fall, e.fall);
         end
         mon_cyc++;
      end
   end

   initial begin
      int   len;
      int   mode;
      logic s, sv, t, r;
      reset = 1'b0;
      sw    = 1'b0;
      tick  = 1'b0;

      // reset held with switch high, then confirmed press
      repeat (5) step_p(1'b0, 1'b1);
      repeat (50) step_p(1'b1, 1'b1);
      // release
      repeat (50) step_p(1'b1, 1'b0);
      // bounce after two ticks in WAIT1, then fresh confirmation
      align();
      repeat (22) step_p(1'b1, 1'b1);
      step_p(1'b1, 1'b0);
      repeat (50) step_p(1'b1, 1'b1);
      // return to high coincides with the third tick in WAIT0
      align();
      repeat (SIM_OFS) step_p(1'b1, 1'b0);
      repeat (40) step_p(1'b1, 1'b1);
      // clean release
      repeat (50) step_p(1'b1, 1'b0);
      // reset pulse in the middle of WAIT1
      align();
      repeat (22) step_p(1'b1, 1'b1);
      step_p(1'b0, 1'b1);
      repeat (50) step_p(1'b1, 1'b1);
      // tick held high: tightest spacing
      repeat (10) step(1'b1, 1'b0, 1'b1);
      repeat (10) step(1'b1, 1'b1, 1'b1);
      repeat (10) step(1'b1, 1'b0, 1'b1);

      // random segments with glitches, mixed tick patterns, rare resets
      repeat (100) begin
         len  = $urandom_range(1, 40);
         s    = 1'($urandom_range(0, 1));
         mode = $urandom_range(0, 2);
         for (int i = 0; i < len; i++) begin
            if (mode == 0) t = ((cyc % 10) == 9);
            else if (mode == 1) t = ($urandom_range(0, 3) == 0);
            else t = 1'b1;
            r  = ($urandom_range(0, 299) != 0);
            sv = ($urandom_range(0, 14) == 0) ? ~s : s;
            step(r, sv, t);
         end
      end

      @(posedge clk);
      #3;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
